// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: Diff = A - B - bin, one full-subtractor cell and a
//   registered borrow, one bit per clock, LSB first. A start/done handshake
//   launches one operation and collects its result.
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous active-high reset
//     start  request; sampled only when not busy (IDLE or DONE)
//     A, B   minuend / subtrahend, captured on the accepting edge
//     bin    borrow-in, captured on the accepting edge
//     Diff   registered result, holds the last completed value
//     bout   registered borrow-out of the MSB (unsigned underflow)
//     ovf    registered two's-complement overflow flag
//     busy   high while bits are being processed
//     done   one-cycle pulse when Diff/bout/ovf update
module serial_subtractor #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            bin,
  output logic [SIZE-1:0] Diff,
  output logic            bout,
  output logic            ovf,
  output logic            busy,
  output logic            done
);

  localparam int            CW   = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] a_sr, b_sr, res;
  logic            borrow;
  logic            a_msb, b_msb;   // captured operand sign bits for ovf
  logic [CW-1:0]   cnt;

  // Full-subtractor cell on the current LSBs
  logic            d, borrow_nxt;
  logic [SIZE-1:0] res_nxt;

  assign d          = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);

  // New difference bits enter at the MSB so the result is aligned after SIZE shifts
  generate
    if (SIZE == 1) begin : g_res1
      assign res_nxt = d;
    end else begin : g_resn
      assign res_nxt = {d, res[SIZE-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= bin;
            a_msb  <= A[SIZE-1];
            b_msb  <= B[SIZE-1];
            res    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res    <= res_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Outputs update together with the done pulse
            Diff  <= res_nxt;
            bout  <= borrow_nxt;
            ovf   <= (a_msb != b_msb) && (res_nxt[SIZE-1] != a_msb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
